noc_rr_sched: RTL and testbench
===============================

# noc_rr_sched

Round-robin scheduler that shares the root link of the NoC tree among `2**log_n_req` requesters. Each requester owns a one-flit holding register. Per-destination credit counters keep any adder from receiving more than `max_credit` unreturned flits. The block replaces the fixed-priority root merge: its registered output feeds the root dispatcher directly, in the same `{ctrl, addr, data}` flit layout.

## Interface
Parameters:
- `bit_width`, 16, payload width
- `log_n_req`, 3, log2 of requester count N
- `log_n_add`, 3, log2 of destination count D; also the address field width
- `ctrl_bit`, 1, control field width; flit valid = bit W-1 (MSB of ctrl field)
- `max_credit`, 4, credits per destination; 1..`2**log_credit`-1
- `log_credit`, 3, credit counter width
- Derived W = `bit_width`+`log_n_add`+`ctrl_bit`. Flit = `{ctrl[W-1 -: ctrl_bit], addr[bit_width+log_n_add-1 -: log_n_add], data[bit_width-1:0]}`.

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `in`  in  W*N  requester flits; requester i at `[i*W +: W]`
- `stall`  out  N  1 = holding register i occupied; requester i must hold its flit
- `out`  out  W  registered flit to the root dispatcher
- `out_ready`  in  1  downstream accepts `out` when out valid & `out_ready`
- `credit_ret`  in  D  one-cycle pulse per destination, returns one credit
- `credit_empty`  out  D  1 = destination credit counter is 0
- `credit_err`  out  1  sticky; a return arrived at a counter already at `max_credit`

## Operation
- **Capture.** At each edge, if valid(in i)=1 and `stall[i]`=0, flit i is loaded into holding register i. When `stall[i]`=1, `in` i is ignored. `stall[i]` equals the registered occupied flag.
- **Eligibility.** Holding register i is eligible when it is occupied and the credit counter for its addr is >0.
- **Slot free.** The output slot is free when `out` is invalid, or when `out` is valid & `out_ready`=1 (drain and reload in the same cycle).
- **Grant.** When the slot is free, the first eligible index searching ptr, ptr+1, …, N-1, 0, … wins. On the grant edge:
  - `out` <= winner flit;
  - holding register freed;
  - credit[addr] decremented;
  - ptr <= (winner+1) mod N.
- **No grant.** With no eligible requester, ptr is unchanged. If the slot drained, `out` <= all zeros.
- **Stall.** When the slot is not free (valid & !`out_ready`), `out` holds every bit stable and no grant occurs.
- **Credit arithmetic, per destination:**
  - next = cnt − grant_hit + ret.
  - A grant and a return to the same destination in the same cycle leave the count unchanged.
  - If ret=1 at cnt=`max_credit` with no grant hit, cnt stays `max_credit` and `credit_err` <= 1.
- **Blocking.** A requester blocked on zero credit does not block others. It is skipped until its credit returns.
- **Reset.** Reset asserted mid-operation discards all held and output flits.

## Timing
- **Reset values:**
  - `stall` = 0;
  - `out` = 0;
  - ptr = 0;
  - all credits = `max_credit`;
  - `credit_empty` = 0;
  - `credit_err` = 0.
- **Latency.** A flit presented with `stall`=0 before edge k is held after edge k and appears on `out` after edge k+1 at the earliest (2 cycles).
- **Freed register.** A freed holding register drops `stall` the cycle after the grant. Per-requester throughput is therefore at most 1 flit per 2 cycles; aggregate throughput is 1 flit per cycle.
- **`credit_empty`.** Registered; reflects the counter after the same edge that updates it.
- **Fairness.** With all N requesters continuously eligible, each is granted exactly once in any N consecutive grants.

## Test plan
- **Reset.** Assert `rst`=0 mid-traffic with `out` valid and two held flits. Required response: immediately `out`=0, `stall`=0, credits=4, `credit_err`=0. After `rst`=1, no stale flit appears.
- **Round robin.** All 8 requesters present addr=i, data=0x100+i, `out_ready`=1. Required response: `out` data sequence 0x100..0x107. Each `stall[i]` rises the cycle after capture and falls the cycle after its grant.
- **Credit exhaustion.** Requester 0 streams 6 flits to addr 5 with no `credit_ret`. Required response: exactly 4 are delivered, then `credit_empty[5]`=1 and requester 0 holds `stall[0]`=1. Meanwhile requester 1, addr 2, keeps flowing. One `credit_ret[5]` pulse releases exactly one more flit.
- **Backpressure.** Hold `out_ready`=0 for 5 cycles with `out` valid. Required response: `out` is bit-stable and no credit changes. On `out_ready`=1, the next grant loads in the same cycle, with no bubble.
- **Simultaneous credit events.**
  - A grant to addr 3 and `credit_ret[3]` in the same cycle leave the count unchanged.
  - A `credit_ret[3]` at count 4 sets `credit_err`=1 and the count stays 4.
- **Wrap-around.** Only requesters 7 and 0 are active with ptr=7. Required response: grants alternate 7, 0, 7, 0.

Source files
------------

// File: rtl/noc_rr_sched.sv
// noc_rr_sched -- round-robin scheduler for the root link of the NoC tree.
//
// Each of N = 2**log_n_req requesters owns a one-flit holding register.
// Occupied registers whose destination still has credit compete for the single
// registered output slot. A rotating pointer gives each requester a fair turn.
// Per-destination credit counters stop any adder from holding more than
// max_credit unreturned flits.
//
// Flit layout (W = bit_width + log_n_add + ctrl_bit):
//   {ctrl[W-1 -: ctrl_bit], addr[bit_width +: log_n_add], data[bit_width-1:0]}
//   The flit is valid when bit W-1 is set.
//
// Ports:
//   clk           rising-edge clock
//   rst           asynchronous active-low reset
//   in            N requester flits, requester i at [i*W +: W]
//   stall         per requester: holding register occupied, requester must hold its flit
//   out           registered flit to the root dispatcher
//   out_ready     downstream accepts out when out is valid and out_ready is high
//   credit_ret    per destination: one-cycle pulse that returns one credit
//   credit_empty  per destination: credit counter is zero (registered)
//   credit_err    sticky: a credit came back to a counter already at max_credit
module noc_rr_sched #(
  parameter int bit_width  = 16,
  parameter int log_n_req  = 3,
  parameter int log_n_add  = 3,
  parameter int ctrl_bit   = 1,
  parameter int max_credit = 4,
  parameter int log_credit = 3
) (
  input  logic                                                        clk,
  input  logic                                                        rst,
  input  logic [(bit_width+log_n_add+ctrl_bit)*(2**log_n_req)-1:0]    in,
  output logic [2**log_n_req-1:0]                                     stall,
  output logic [bit_width+log_n_add+ctrl_bit-1:0]                     out,
  input  logic                                                        out_ready,
  input  logic [2**log_n_add-1:0]                                     credit_ret,
  output logic [2**log_n_add-1:0]                                     credit_empty,
  output logic                                                        credit_err
);

  localparam int W = bit_width + log_n_add + ctrl_bit;
  localparam int N = 2 ** log_n_req;
  localparam int D = 2 ** log_n_add;

  typedef logic [W-1:0]          flit_t;
  typedef logic [log_n_req-1:0]  idx_t;
  typedef logic [log_n_add-1:0]  addr_t;
  typedef logic [log_credit-1:0] cnt_t;

  function automatic logic flit_valid(flit_t f);
    return f[W-1];
  endfunction

  function automatic addr_t flit_addr(flit_t f);
    return f[bit_width +: log_n_add];
  endfunction

  // State
  flit_t          hold_q [N];
  logic [N-1:0]   occ_q;
  flit_t          out_q;
  idx_t           ptr_q;
  cnt_t           cnt_q [D];
  logic [D-1:0]   empty_q;
  logic           err_q;

  // Arbitration / credit next-state
  logic           slot_free;
  logic [N-1:0]   eligible;
  logic           found;
  idx_t           win;
  idx_t           idx;
  logic           grant;
  addr_t          win_addr;
  cnt_t           cnt_d [D];
  logic [D-1:0]   empty_d;
  logic           err_d;
  logic           hit;

  // Search ptr, ptr+1, ... wrapping modulo N; N is a power of two, so the
  // natural overflow of idx_t performs the wrap.
  always_comb begin
    // NOTE: every variable gets a default before any conditional assignment,
    // so no path leaves a value unassigned and no latch is inferred.
    slot_free = !flit_valid(out_q) || out_ready;
    found     = 1'b0;
    win       = ptr_q;
    idx       = ptr_q;
    eligible  = '0;
    for (int i = 0; i < N; i++) begin
      eligible[i] = occ_q[i] && (cnt_q[flit_addr(hold_q[i])] != '0);
    end
    for (int k = 0; k < N; k++) begin
      idx = ptr_q + idx_t'(k);
      if (!found && eligible[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    grant    = slot_free && found;
    win_addr = flit_addr(hold_q[win]);
  end

  // Credit arithmetic: next = cnt - grant_hit + ret. A return at a full counter
  // is dropped and flagged instead of wrapping.
  always_comb begin
    err_d   = err_q;
    empty_d = '0;
    hit     = 1'b0;
    for (int d = 0; d < D; d++) begin
      cnt_d[d] = cnt_q[d];
      hit      = grant && (win_addr == addr_t'(d));
      if (hit && !credit_ret[d]) begin
        cnt_d[d] = cnt_q[d] - cnt_t'(1);
      end else if (!hit && credit_ret[d]) begin
        if (cnt_q[d] == cnt_t'(max_credit)) begin
          err_d = 1'b1;
        end else begin
          cnt_d[d] = cnt_q[d] + cnt_t'(1);
        end
      end
      empty_d[d] = (cnt_d[d] == '0);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ_q   <= '0;
      out_q   <= '0;
      ptr_q   <= '0;
      empty_q <= '0;
      err_q   <= 1'b0;
      for (int d = 0; d < D; d++) begin
        cnt_q[d] <= cnt_t'(max_credit);
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (grant && (win == idx_t'(i))) begin
          occ_q[i] <= 1'b0;
        end else if (!occ_q[i] && flit_valid(in[i*W +: W])) begin
          occ_q[i] <= 1'b1;
        end
      end
      if (grant) begin
        out_q <= hold_q[win];
        ptr_q <= win + idx_t'(1);
      end else if (slot_free) begin
        out_q <= '0;
      end
      cnt_q   <= cnt_d;
      empty_q <= empty_d;
      err_q   <= err_d;
    end
  end

  // NOTE: the holding-register payload has no reset; occ_q qualifies it, and
  // a register is only ever read after a capture has set its occupied flag.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (!occ_q[i] && flit_valid(in[i*W +: W])) begin
        hold_q[i] <= in[i*W +: W];
      end
    end
  end

  assign stall        = occ_q;
  assign out          = out_q;
  assign credit_empty = empty_q;
  assign credit_err   = err_q;

endmodule

// File: tb/tb_noc_rr_sched.sv
// Self-checking bench for noc_rr_sched. Per-requester scoreboard queues hold
// the flits each requester was given; every flit the DUT grants onto out is
// popped from its requester's queue and compared. A small credit model follows
// grants and returns and is compared with credit_empty / credit_err each cycle.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge.
module tb_noc_rr_sched;

  localparam int BW   = 16;
  localparam int LN   = 3;
  localparam int LA   = 3;
  localparam int CB   = 1;
  localparam int MAXC = 4;
  localparam int LC   = 3;
  localparam int W    = BW + LA + CB;
  localparam int N    = 2 ** LN;
  localparam int D    = 2 ** LA;

  logic             clk = 1'b0;
  logic             rst;
  logic [W*N-1:0]   in_flits;
  logic [N-1:0]     stall;
  logic [W-1:0]     out_flit;
  logic             out_ready;
  logic [D-1:0]     credit_ret;
  logic [D-1:0]     credit_empty;
  logic             credit_err;

  noc_rr_sched #(
    .bit_width(BW), .log_n_req(LN), .log_n_add(LA),
    .ctrl_bit(CB), .max_credit(MAXC), .log_credit(LC)
  ) dut (
    .clk(clk), .rst(rst), .in(in_flits), .stall(stall), .out(out_flit),
    .out_ready(out_ready), .credit_ret(credit_ret),
    .credit_empty(credit_empty), .credit_err(credit_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [W-1:0] src_q [N][$];   // flits still to be presented per requester
  logic [W-1:0] exp_q [N][$];   // scoreboard: flits still expected per requester
  int           got_ids [$];    // requester id of each grant, in order
  int           deliv [N];
  int           n_grant = 0;
  int           ret_cnt [D];    // credit returns still to be pulsed
  logic [D-1:0] ret_mask;       // destinations that return credit automatically
  logic [N-1:0] cap;
  logic         prev_free;
  logic [D-1:0] ret_prev;
  int           m_cnt [D];
  logic         m_err;
  logic [D-1:0] m_empty;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] mk_flit(input int a, input int d);
    return {1'b1, LA'(a), BW'(d)};
  endfunction

  task automatic enqueue(input int r, input int a, input int d);
    logic [W-1:0] f;
    f = mk_flit(a, d);
    src_q[r].push_back(f);
    exp_q[r].push_back(f);
  endtask

  task automatic model_reset();
    for (int d = 0; d < D; d++) begin
      m_cnt[d]   = MAXC;
      ret_cnt[d] = 0;
    end
    m_err     = 1'b0;
    prev_free = 1'b1;
    ret_prev  = '0;
    cap       = '0;
  endtask

  // One clock cycle: drive inputs now (just after an edge), check the DUT on
  // the falling edge, then advance past the next rising edge.
  task automatic cycle();
    logic          new_grant;
    logic [D-1:0]  hit;
    int            id;
    int            addr;
    for (int i = 0; i < N; i++) begin
      in_flits[i*W +: W] = (src_q[i].size() != 0) ? src_q[i][0] : '0;
    end
    for (int d = 0; d < D; d++) begin
      credit_ret[d] = (ret_cnt[d] > 0);
      if (ret_cnt[d] > 0) ret_cnt[d]--;
    end
    @(negedge clk);
    if (rst) begin
      new_grant = out_flit[W-1] && prev_free;
      hit = '0;
      if (new_grant) begin
        id   = int'(out_flit[LN-1:0]);
        addr = int'(out_flit[BW +: LA]);
        hit[addr] = 1'b1;
        n_grant++;
        got_ids.push_back(id);
        deliv[id]++;
        check("sb_pending", 64'(exp_q[id].size() != 0), 64'(1));
        if (exp_q[id].size() != 0) check("sb_flit", 64'(out_flit), 64'(exp_q[id].pop_front()));
        check("stall_drop", 64'(stall[id]), 64'(0));
        if (ret_mask[addr]) ret_cnt[addr]++;
      end
      for (int d = 0; d < D; d++) begin
        if (hit[d] && !ret_prev[d]) m_cnt[d]--;
        else if (!hit[d] && ret_prev[d]) begin
          if (m_cnt[d] == MAXC) m_err = 1'b1;
          else m_cnt[d]++;
        end
        m_empty[d] = (m_cnt[d] == 0);
      end
      check("credit_empty", 64'(credit_empty), 64'(m_empty));
      check("credit_err", 64'(credit_err), 64'(m_err));
      ret_prev  = credit_ret;
      prev_free = !out_flit[W-1] || out_ready;
      for (int i = 0; i < N; i++) cap[i] = in_flits[i*W + W-1] && !stall[i];
    end
    @(posedge clk);
    #1;
    if (rst) begin
      for (int i = 0; i < N; i++) if (cap[i]) void'(src_q[i].pop_front());
    end
  endtask

  function automatic bit busy();
    for (int i = 0; i < N; i++) if (exp_q[i].size() != 0 || src_q[i].size() != 0) return 1'b1;
    for (int d = 0; d < D; d++) if (ret_cnt[d] != 0) return 1'b1;
    return out_flit[W-1];
  endfunction

  task automatic idle();
    int budget = 0;
    while (busy() && budget < 300) begin
      cycle();
      budget++;
    end
    check("idle_timeout", 64'(busy()), 64'(0));
    repeat (2) cycle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, d1, d4, g0;
    logic [W-1:0] snap;
    rst        = 1'b0;
    out_ready  = 1'b1;
    in_flits   = '0;
    credit_ret = '0;
    ret_mask   = '1;
    for (int i = 0; i < N; i++) deliv[i] = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    // Reset values
    check("rst_stall", 64'(stall), 64'(0));
    check("rst_out", 64'(out_flit), 64'(0));
    check("rst_empty", 64'(credit_empty), 64'(0));
    check("rst_err", 64'(credit_err), 64'(0));
    rst = 1'b1;

    // Round robin: all 8 at once from ptr = 0
    for (int i = 0; i < N; i++) enqueue(i, i, 16'h100 + i);
    got_ids.delete();
    cycle();
    check("rr_stall_rise", 64'(stall), 64'(8'hFF));
    idle();
    check("rr_count", 64'(got_ids.size()), 64'(8));
    for (int k = 0; k < 8 && k < got_ids.size(); k++) check("rr_order", 64'(got_ids[k]), 64'(k));

    // Credit exhaustion: destination 5 gets no automatic returns
    ret_mask = ~8'h20;
    d0 = deliv[0];
    d1 = deliv[1];
    for (int s = 0; s < 6; s++) begin
      enqueue(0, 5, 16'h0300 | (s << 4));
      enqueue(1, 2, 16'h0300 | (s << 4) | 1);
    end
    repeat (40) cycle();
    check("ex_deliv0", 64'(deliv[0] - d0), 64'(4));
    check("ex_deliv1", 64'(deliv[1] - d1), 64'(6));
    check("ex_empty5", 64'(credit_empty[5]), 64'(1));
    check("ex_stall0", 64'(stall[0]), 64'(1));
    ret_cnt[5] = 1;
    repeat (10) cycle();
    check("ex_one_more", 64'(deliv[0] - d0), 64'(5));
    check("ex_empty5b", 64'(credit_empty[5]), 64'(1));
    check("ex_stall0b", 64'(stall[0]), 64'(1));
    ret_mask = '1;
    ret_cnt[5] = 4;
    idle();

    // Backpressure
    enqueue(2, 1, 16'h0402);
    enqueue(2, 1, 16'h0412);
    enqueue(3, 4, 16'h0403);
    enqueue(3, 4, 16'h0413);
    for (int t = 0; t < 20; t++) begin
      cycle();
      if (out_flit[W-1]) break;
    end
    check("bp_valid", 64'(out_flit[W-1]), 64'(1));
    out_ready = 1'b0;
    snap = out_flit;
    cycle();
    g0 = n_grant;
    check("bp_hold", 64'(out_flit), 64'(snap));
    repeat (4) begin
      cycle();
      check("bp_hold", 64'(out_flit), 64'(snap));
    end
    check("bp_no_grant", 64'(n_grant - g0), 64'(0));
    out_ready = 1'b1;
    cycle();
    check("bp_reload_valid", 64'(out_flit[W-1]), 64'(1));
    check("bp_reload_new", 64'(out_flit != snap), 64'(1));
    idle();

    // Grant and return to destination 3 on the same edge
    ret_mask  = ~8'h08;
    d4        = deliv[4];
    out_ready = 1'b0;
    enqueue(4, 3, 16'h0504);
    enqueue(4, 3, 16'h0514);
    repeat (4) cycle();
    check("sim_held", 64'(stall[4]), 64'(1));
    check("sim_out_valid", 64'(out_flit[W-1]), 64'(1));
    out_ready  = 1'b1;
    ret_cnt[3] = 1;
    cycle();
    for (int s = 2; s < 5; s++) enqueue(4, 3, 16'h0504 | (s << 4));
    repeat (20) cycle();
    check("sim_deliv", 64'(deliv[4] - d4), 64'(5));
    check("sim_empty3", 64'(credit_empty[3]), 64'(1));
    ret_cnt[3] = 4;
    repeat (8) cycle();
    check("err_before", 64'(credit_err), 64'(0));
    ret_cnt[3] = 1;
    repeat (3) cycle();
    check("err_set", 64'(credit_err), 64'(1));
    check("err_empty3", 64'(credit_empty[3]), 64'(0));
    d4 = deliv[4];
    for (int s = 0; s < 5; s++) enqueue(4, 3, 16'h0604 | (s << 4));
    repeat (30) cycle();
    check("err_cap4", 64'(deliv[4] - d4), 64'(4));
    check("err_empty3b", 64'(credit_empty[3]), 64'(1));
    check("err_stall4", 64'(stall[4]), 64'(1));
    ret_mask   = '1;
    ret_cnt[3] = 4;
    idle();

    // Wrap-around: park ptr at 7, then only requesters 7 and 0
    enqueue(6, 6, 16'h0706);
    idle();
    got_ids.delete();
    enqueue(7, 7, 16'h0707);
    enqueue(7, 7, 16'h0717);
    enqueue(0, 0, 16'h0700);
    enqueue(0, 0, 16'h0710);
    idle();
    check("wrap_count", 64'(got_ids.size()), 64'(4));
    for (int k = 0; k < 4 && k < got_ids.size(); k++)
      check("wrap_order", 64'(got_ids[k]), 64'((k % 2 == 0) ? 7 : 0));

    // Reset mid-traffic: out valid and two held flits
    out_ready = 1'b0;
    enqueue(1, 1, 16'h0801);
    enqueue(1, 1, 16'h0811);
    enqueue(2, 2, 16'h0802);
    enqueue(2, 2, 16'h0812);
    repeat (3) cycle();
    check("mid_out_valid", 64'(out_flit[W-1]), 64'(1));
    check("mid_held", 64'(stall), 64'(8'h06));
    rst = 1'b0;
    #1;
    check("mid_rst_out", 64'(out_flit), 64'(0));
    check("mid_rst_stall", 64'(stall), 64'(0));
    check("mid_rst_empty", 64'(credit_empty), 64'(0));
    check("mid_rst_err", 64'(credit_err), 64'(0));
    for (int i = 0; i < N; i++) begin
      src_q[i].delete();
      exp_q[i].delete();
    end
    in_flits   = '0;
    credit_ret = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst       = 1'b1;
    out_ready = 1'b1;
    g0        = n_grant;
    repeat (10) cycle();
    check("post_rst_no_grant", 64'(n_grant - g0), 64'(0));
    check("post_rst_out", 64'(out_flit), 64'(0));
    check("post_rst_stall", 64'(stall), 64'(0));
    // Credits restored to the full allowance by reset
    ret_mask = ~8'h01;
    d0 = deliv[0];
    for (int s = 0; s < 5; s++) enqueue(0, 0, 16'h0900 | (s << 4));
    repeat (30) cycle();
    check("post_rst_credit", 64'(deliv[0] - d0), 64'(4));
    check("post_rst_empty0", 64'(credit_empty[0]), 64'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
